// File: rtl/traffic_phase_controller_if.sv
// rtl/traffic_phase_controller_if.sv - Emergency-decoder inputs and lamp outputs of the traffic phase controller.
interface traffic_phase_controller_if;
  logic [1:0] Em_Signal_Pos;
  logic       Pos_select;
  logic       Hold;
  logic [3:0] green;
  logic [3:0] yellow;
  logic [3:0] red;
  logic [1:0] cur_pos;
  logic       em_active;

  modport master (
    output Em_Signal_Pos, Pos_select, Hold,
    input  green, yellow, red, cur_pos, em_active
  );

  modport slave (
    input  Em_Signal_Pos, Pos_select, Hold,
    output green, yellow, red, cur_pos, em_active
  );
endinterface

// File: rtl/traffic_phase_controller.sv
// rtl/traffic_phase_controller.sv - Four-position signal sequencer with emergency preemption.
// Define ALL_RED_EN to insert the all-red clearance phase between yellow and the next green.
module traffic_phase_controller #(
  parameter int GREEN_TICKS   = 8,
  parameter int YELLOW_TICKS  = 3,
  parameter int ALL_RED_TICKS = 2,
  parameter int CNT_W         = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  traffic_phase_controller_if.slave bus
);

  typedef enum logic [1:0] {
    S_GREEN    = 2'd0,
    S_YELLOW   = 2'd1,
    S_ALL_RED  = 2'd2,
    S_EM_GREEN = 2'd3
  } state_t;

`ifdef ALL_RED_EN
  localparam bit HAS_ALL_RED = 1'b1;
`else
  localparam bit HAS_ALL_RED = 1'b0;
`endif

  localparam logic [CNT_W-1:0] GRN_LD = CNT_W'(GREEN_TICKS - 1);
  localparam logic [CNT_W-1:0] YEL_LD = CNT_W'(YELLOW_TICKS - 1);
  localparam logic [CNT_W-1:0] AR_LD  = CNT_W'(ALL_RED_TICKS - 1);
  localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);

  logic       req_meta_q, req_s_q;
  logic [1:0] pos_meta_q, pos_s_q;

  state_t           state_q, state_d;
  logic [1:0]       pos_q, pos_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  state_t     exit_state;
  logic [1:0] exit_pos;
  logic       cnt_zero;

  // Two-flop synchroniser: every decision below looks only at the _s values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_meta_q <= 1'b0;
      req_s_q    <= 1'b0;
      pos_meta_q <= 2'd0;
      pos_s_q    <= 2'd0;
    end else begin
      req_meta_q <= bus.Pos_select & bus.Hold;
      req_s_q    <= req_meta_q;
      pos_meta_q <= bus.Em_Signal_Pos;
      pos_s_q    <= pos_meta_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_GREEN;
      pos_q   <= 2'd0;
      cnt_q   <= GRN_LD;
    end else begin
      state_q <= state_d;
      pos_q   <= pos_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    cnt_zero   = (cnt_q == '0);
    exit_state = req_s_q ? S_EM_GREEN : S_GREEN;
    exit_pos   = req_s_q ? pos_s_q : pos_q + 2'd1;

    state_d = state_q;
    pos_d   = pos_q;
    cnt_d   = cnt_q;

    unique case (state_q)
      S_GREEN: begin
        if (req_s_q && (pos_s_q == pos_q)) begin
          state_d = S_EM_GREEN;
        end else if (req_s_q || cnt_zero) begin
          state_d = S_YELLOW;
          cnt_d   = YEL_LD;
        end else begin
          cnt_d = cnt_q - ONE;
        end
      end
      S_YELLOW: begin
        if (!cnt_zero) begin
          cnt_d = cnt_q - ONE;
        end else if (HAS_ALL_RED) begin
          state_d = S_ALL_RED;
          cnt_d   = AR_LD;
        end else begin
          // Without clearance the yellow exit makes the all-red decision itself.
          state_d = exit_state;
          pos_d   = exit_pos;
          cnt_d   = GRN_LD;
        end
      end
      S_ALL_RED: begin
        if (cnt_zero) begin
          state_d = exit_state;
          pos_d   = exit_pos;
          cnt_d   = GRN_LD;
        end else begin
          cnt_d = cnt_q - ONE;
        end
      end
      S_EM_GREEN: begin
        if (!req_s_q || (pos_s_q != pos_q)) begin
          state_d = S_YELLOW;
          cnt_d   = YEL_LD;
        end
      end
      default: begin
        state_d = S_GREEN;
        cnt_d   = GRN_LD;
      end
    endcase
  end

  always_comb begin
    bus.green     = 4'b0000;
    bus.yellow    = 4'b0000;
    bus.em_active = 1'b0;
    if ((state_q == S_GREEN) || (state_q == S_EM_GREEN)) begin
      bus.green = 4'b0001 << pos_q;
    end
    if (state_q == S_YELLOW) begin
      bus.yellow = 4'b0001 << pos_q;
    end
    if (state_q == S_EM_GREEN) begin
      bus.em_active = 1'b1;
    end
    bus.red     = ~(bus.green | bus.yellow);
    bus.cur_pos = pos_q;
  end

endmodule

// File: tb/tb_traffic_phase_controller.sv
// tb/tb_traffic_phase_controller.sv - Scoreboard bench: expected lamp transitions queued, monitor compares on each output change.
module tb_traffic_phase_controller;

  localparam int G = 8;
  localparam int Y = 3;
`ifdef ALL_RED_EN
  localparam int A = 2;
`else
  localparam int A = 0;
`endif
  localparam int P = G + Y + A;
  localparam logic [14:0] RESET_SNAP = {4'b0001, 4'b0000, 4'b1110, 2'd0, 1'b0};

  typedef struct {
    int         cyc;
    logic [14:0] snap;
  } exp_t;

  logic clk;
  logic rst_n;
  int   cyc;
  int   n_tests;
  int   n_fail;
  bit   mon_en;
  exp_t exp_q[$];

  traffic_phase_controller_if bus ();

  traffic_phase_controller #(
    .GREEN_TICKS  (G),
    .YELLOW_TICKS (Y),
    .ALL_RED_TICKS(2),
    .CNT_W        (8)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  function automatic logic [14:0] mk(input logic [3:0] g, input logic [3:0] y,
                                     input logic [1:0] p, input logic em);
    return {g, y, ~(g | y), p, em};
  endfunction

  task automatic push(input int c, input logic [14:0] s);
    exp_t e;
    e.cyc  = c;
    e.snap = s;
    exp_q.push_back(e);
  endtask

  task automatic push_green(input int c, input logic [1:0] p);
    push(c, mk(4'b0001 << p, 4'b0000, p, 1'b0));
  endtask

  task automatic push_yellow(input int c, input logic [1:0] p);
    push(c, mk(4'b0000, 4'b0001 << p, p, 1'b0));
  endtask

  task automatic push_allred(input int c, input logic [1:0] p);
    if (A > 0) push(c, mk(4'b0000, 4'b0000, p, 1'b0));
  endtask

  task automatic push_em(input int c, input logic [1:0] p);
    push(c, mk(4'b0001 << p, 4'b0000, p, 1'b1));
  endtask

  // Monitor: every change of the lamp/position outputs consumes one expectation.
  initial begin
    logic [14:0] prev, cur;
    exp_t e;
    prev = RESET_SNAP;
    forever begin
      @(negedge clk);
      cur = {bus.green, bus.yellow, bus.red, bus.cur_pos, bus.em_active};
      if (!mon_en) begin
        prev = RESET_SNAP;
      end else if (cur != prev) begin
        n_tests++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_change cyc=%0d got=%b required=no change", cyc, cur);
        end else begin
          e = exp_q.pop_front();
          if ((e.cyc != cyc) || (e.snap != cur)) begin
            n_fail++;
            $display("FAIL transition got cyc=%0d g/y/r/pos/em=%b required cyc=%0d %b",
                     cyc, cur, e.cyc, e.snap);
          end
        end
        prev = cur;
      end
    end
  end

  task automatic check_now(input string name, input logic [3:0] act, input logic [3:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s got=%b required=%b", name, act, req);
    end
  endtask

  task automatic run_reset();
    mon_en           = 1'b0;
    bus.Hold          = 1'b0;
    bus.Pos_select    = 1'b0;
    bus.Em_Signal_Pos = 2'd0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_now("reset_green",  bus.green,  4'b0001);
    check_now("reset_yellow", bus.yellow, 4'b0000);
    check_now("reset_red",    bus.red,    4'b1110);
    check_now("reset_pos",    {2'b00, bus.cur_pos}, 4'd0);
    check_now("reset_em",     {3'b000, bus.em_active}, 4'd0);
    @(negedge clk);
    rst_n  = 1'b1;
    mon_en = 1'b1;
  endtask

  task automatic wait_cyc(input int c);
    int guard = 0;
    while (cyc < c && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    if (cyc != c) begin
      n_tests++;
      n_fail++;
      $display("FAIL wait_cycle got=%0d required=%0d", cyc, c);
    end
  endtask

  task automatic finish_scenario(input string name, input int last);
    wait_cyc(last + 1);
    @(negedge clk);
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s_pending got=%0d transitions left required=0", name, exp_q.size());
    end
    exp_q.delete();
  endtask

  task automatic set_req(input logic hold, input logic sel, input logic [1:0] p);
    bus.Hold          = hold;
    bus.Pos_select    = sel;
    bus.Em_Signal_Pos = p;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    mon_en  = 1'b0;
    rst_n   = 1'b1;
    set_req(1'b0, 1'b0, 2'd0);

    // Free rotation with Hold set but no single switch: request must be ignored.
    run_reset();
    set_req(1'b1, 1'b0, 2'd2);
    for (int k = 0; k <= 4; k++) begin
      if (k > 0) push_green(k * P, 2'(k % 4));
      if (k < 4) begin
        push_yellow(k * P + G, 2'(k));
        push_allred(k * P + G + Y, 2'(k));
      end
    end
    finish_scenario("rotation", 4 * P + 2);

    // Preempt pos0 green for pos2, hold long, then drop and resume at pos3.
    run_reset();
    wait_cyc(2);
    set_req(1'b1, 1'b1, 2'd2);
    push_yellow(5, 2'd0);
    push_allred(8, 2'd0);
    push_em(8 + A, 2'd2);
    wait_cyc(120);
    set_req(1'b0, 1'b1, 2'd2);
    push_yellow(123, 2'd2);
    push_allred(126, 2'd2);
    push_green(126 + A, 2'd3);
    finish_scenario("em_hold_drop", 126 + A + 3);

    // Request matches the green position, then moves to pos2, then drops.
    run_reset();
    push_yellow(G, 2'd0);
    push_allred(G + Y, 2'd0);
    push_green(P, 2'd1);
    wait_cyc(P + 1);
    set_req(1'b1, 1'b1, 2'd1);
    push_em(P + 4, 2'd1);
    wait_cyc(P + 20);
    set_req(1'b1, 1'b1, 2'd2);
    push_yellow(P + 23, 2'd1);
    push_allred(P + 26, 2'd1);
    push_em(P + 26 + A, 2'd2);
    wait_cyc(P + 40);
    set_req(1'b0, 1'b0, 2'd2);
    push_yellow(P + 43, 2'd2);
    push_allred(P + 46, 2'd2);
    push_green(P + 46 + A, 2'd3);
    finish_scenario("em_same_move", P + 46 + A + 3);

    // Request lands during yellow: yellow runs full length; resume wraps 3->0.
    run_reset();
    wait_cyc(7);
    set_req(1'b1, 1'b1, 2'd3);
    push_yellow(8, 2'd0);
    push_allred(11, 2'd0);
    push_em(P, 2'd3);
    wait_cyc(P + 10);
    set_req(1'b0, 1'b1, 2'd3);
    push_yellow(P + 13, 2'd3);
    push_allred(P + 16, 2'd3);
    push_green(P + 16 + A, 2'd0);
    finish_scenario("em_in_yellow", P + 16 + A + 3);

    // Asynchronous reset while in emergency green.
    run_reset();
    wait_cyc(2);
    set_req(1'b1, 1'b1, 2'd2);
    push_yellow(5, 2'd0);
    push_allred(8, 2'd0);
    push_em(8 + A, 2'd2);
    finish_scenario("em_before_reset", 19);
    run_reset();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
